mips_cpu_hilo_ctrl: RTL and testbench

MIPS_CPU_HILO_CTRL -- requirements
Module: mips_cpu_hilo_ctrl

---
 rtl/mips_cpu_hilo_pkg.sv | 32 +++
 rtl/mips_cpu_hilo_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mips_cpu_hilo_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_hilo_pkg.sv
// Shared constants and types for the HI/LO instruction controller.
package mips_cpu_hilo_pkg;

  // Instruction funct codes for the HI/LO-class instructions
  localparam logic [5:0] FUNCT_NONE  = 6'b000000;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  // Cycles a multiply holds its operands on the unit, and the divide watchdog limit
  localparam int MUL_HOLD    = 3;
  localparam int DIV_TIMEOUT = 40;

  // Shared counter for the multiply hold and the divide watchdog
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] MUL_LAST     = CNT_W'(MUL_HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DIV_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MUL       = 3'd1,
    ST_DIV_START = 3'd2,
    ST_DIV_RUN   = 3'd3,
    ST_DIV_FIN   = 3'd4
  } hilo_state_e;

endpackage

// File: rtl/mips_cpu_hilo_ctrl.sv
// Decode-side controller for MFHI/MFLO/MTHI/MTLO/MULT/MULTU/DIV/DIVU.
// It sequences the external HI/LO unit, which sits beside this block at
// CPU top level. Multiplies and divides retire at acceptance; later
// HI/LO-class requests stall until the unit is idle again.
module mips_cpu_hilo_ctrl
  import mips_cpu_hilo_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        err_timeout,
  output logic [5:0]  hl_opcode,
  output logic [31:0] hl_a,
  output logic [31:0] hl_b,
  output logic        hl_valid_in,
  input  logic        hl_valid_out,
  input  logic [31:0] hl_hi,
  input  logic [31:0] hl_lo
);

  hilo_state_e      r_state;
  hilo_state_e      w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic [5:0]       r_opcode;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             r_errTimeout;
  logic             w_loadOps;
  logic             w_setErr;

  assign err_timeout = r_errTimeout;

  // Next-state and output decode; all outputs are held inert while reset is low
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_loadOps   = 1'b0;
    w_setErr    = 1'b0;
    stall       = 1'b0;
    rd_data     = 32'h0;
    rd_valid    = 1'b0;
    busy        = 1'b0;
    hl_opcode   = FUNCT_NONE;
    hl_a        = 32'h0;
    hl_b        = 32'h0;
    hl_valid_in = 1'b0;
    if (reset) begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            case (req_funct)
              FUNCT_MTHI, FUNCT_MTLO: begin
                hl_opcode = req_funct;
                hl_a      = req_rs;
              end
              FUNCT_MFHI: begin
                rd_data  = hl_hi;
                rd_valid = 1'b1;
              end
              FUNCT_MFLO: begin
                rd_data  = hl_lo;
                rd_valid = 1'b1;
              end
              FUNCT_MULT, FUNCT_MULTU: begin
                w_loadOps   = 1'b1;
                w_nextCnt   = '0;
                w_nextState = ST_MUL;
              end
              FUNCT_DIV, FUNCT_DIVU: begin
                if (req_rt != 32'h0) begin
                  w_loadOps   = 1'b1;
                  w_nextCnt   = '0;
                  w_nextState = ST_DIV_START;
                end
              end
              default: begin
              end
            endcase
          end
        end
        ST_MUL: begin
          busy      = 1'b1;
          stall     = req_valid;
          hl_opcode = r_opcode;
          hl_a      = r_a;
          hl_b      = r_b;
          if (r_cnt == MUL_LAST) begin
            w_nextCnt   = '0;
            w_nextState = ST_IDLE;
          end else begin
            w_nextCnt = r_cnt + 1'b1;
          end
        end
        ST_DIV_START: begin
          busy        = 1'b1;
          stall       = req_valid;
          hl_opcode   = r_opcode;
          hl_a        = r_a;
          hl_b        = r_b;
          hl_valid_in = 1'b1;
          w_nextCnt   = r_cnt + 1'b1;
          w_nextState = ST_DIV_RUN;
        end
        ST_DIV_RUN: begin
          busy      = 1'b1;
          stall     = req_valid;
          hl_opcode = r_opcode;
          hl_a      = r_a;
          hl_b      = r_b;
          if (hl_valid_out) begin
            w_nextCnt   = '0;
            w_nextState = ST_DIV_FIN;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_nextCnt   = '0;
            w_setErr    = 1'b1;
            w_nextState = ST_IDLE;
          end else begin
            w_nextCnt = r_cnt + 1'b1;
          end
        end
        ST_DIV_FIN: begin
          busy        = 1'b1;
          stall       = req_valid;
          hl_opcode   = r_opcode;
          hl_a        = r_a;
          hl_b        = r_b;
          w_nextState = ST_IDLE;
        end
        default: begin
          w_nextState = ST_IDLE;
        end
      endcase
    end
  end

  // State, counter, latched operands and the sticky watchdog flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_opcode     <= FUNCT_NONE;
      r_a          <= 32'h0;
      r_b          <= 32'h0;
      r_errTimeout <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_loadOps) begin
        r_opcode <= req_funct;
        r_a      <= req_rs;
        r_b      <= req_rt;
      end
      if (w_setErr) begin
        r_errTimeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_hilo_ctrl.sv
// Directed bench for mips_cpu_hilo_ctrl with a behavioural HI/LO unit stub.
module tb_mips_cpu_hilo_ctrl;
  import mips_cpu_hilo_pkg::*;

  localparam int DIV_LAT = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [5:0]  req_funct = 6'h0;
  logic [31:0] req_rs = 32'h0;
  logic [31:0] req_rt = 32'h0;
  logic        stall;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        err_timeout;
  logic [5:0]  hl_opcode;
  logic [31:0] hl_a;
  logic [31:0] hl_b;
  logic        hl_valid_in;
  logic        hl_valid_out;
  logic [31:0] hl_hi;
  logic [31:0] hl_lo;

  int vecCount = 0;
  int missCount = 0;

  logic        stubNoDone = 1'b0;
  logic        stubBusy;
  logic [3:0]  stubCnt;
  logic        stubCommit;
  logic [31:0] stubHi;
  logic [31:0] stubLo;

  mips_cpu_hilo_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_funct    (req_funct),
    .req_rs       (req_rs),
    .req_rt       (req_rt),
    .stall        (stall),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .hl_opcode    (hl_opcode),
    .hl_a         (hl_a),
    .hl_b         (hl_b),
    .hl_valid_in  (hl_valid_in),
    .hl_valid_out (hl_valid_out),
    .hl_hi        (hl_hi),
    .hl_lo        (hl_lo)
  );

  always #5 clk = ~clk;

  assign hl_hi        = stubHi;
  assign hl_lo        = stubLo;
  assign hl_valid_out = stubBusy && (stubCnt == 4'd0) && !stubNoDone;

  // Stub HI/LO unit: moves and multiplies commit every cycle their opcode is
  // present; a divide finishes DIV_LAT cycles after its start pulse and
  // commits on the cycle after done, only if the opcode is still held
  always @(posedge clk) begin
    if (!reset) begin
      stubHi     <= 32'h0;
      stubLo     <= 32'h0;
      stubBusy   <= 1'b0;
      stubCnt    <= 4'd0;
      stubCommit <= 1'b0;
    end else begin
      stubCommit <= 1'b0;
      case (hl_opcode)
        FUNCT_MTHI:  stubHi <= hl_a;
        FUNCT_MTLO:  stubLo <= hl_a;
        FUNCT_MULT:  {stubHi, stubLo} <= 64'($signed(hl_a)) * 64'($signed(hl_b));
        FUNCT_MULTU: {stubHi, stubLo} <= {32'h0, hl_a} * {32'h0, hl_b};
        default: begin
        end
      endcase
      if (hl_valid_in) begin
        stubBusy <= 1'b1;
        stubCnt  <= 4'(DIV_LAT);
      end else if (stubBusy) begin
        if (stubCnt != 4'd0) begin
          stubCnt <= stubCnt - 4'd1;
        end else if (!stubNoDone) begin
          stubBusy   <= 1'b0;
          stubCommit <= 1'b1;
        end
      end
      if (stubCommit && hl_opcode == FUNCT_DIV) begin
        stubLo <= 32'($signed(hl_a) / $signed(hl_b));
        stubHi <= 32'($signed(hl_a) % $signed(hl_b));
      end else if (stubCommit && hl_opcode == FUNCT_DIVU) begin
        stubLo <= hl_a / hl_b;
        stubHi <= hl_a % hl_b;
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] f,
                               input logic [31:0] rs, input logic [31:0] rt);
    req_valid = v;
    req_funct = f;
    req_rs    = rs;
    req_rt    = rt;
  endtask

  // Hold the current request until it stops stalling (bounded), counting
  // stalled cycles and divide start pulses seen along the way
  task automatic waitStall(output int cycles, output int vins);
    cycles = 0;
    vins   = 0;
    for (int i = 0; i < 60; i++) begin
      if (hl_valid_in) vins++;
      if (!stall) break;
      cycles++;
      nextCycle();
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    applyStimulus(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
    nextCycle();
    nextCycle();
    #1;
    vecCount++; if (stall !== 1'b0) begin missCount++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    vecCount++; if (rd_valid !== 1'b0) begin missCount++; $display("[TB] FAIL reset_rd_valid: got %b want 0", rd_valid); end
    vecCount++; if (err_timeout !== 1'b0) begin missCount++; $display("[TB] FAIL reset_err: got %b want 0", err_timeout); end
    applyStimulus(1'b1, FUNCT_MTHI, 32'hDEAD, 32'h0);
    #1;
    vecCount++; if (hl_opcode !== 6'h0) begin missCount++; $display("[TB] FAIL reset_opcode: got %h want 00", hl_opcode); end
    vecCount++; if (hl_valid_in !== 1'b0) begin missCount++; $display("[TB] FAIL reset_valid_in: got %b want 0", hl_valid_in); end
    applyStimulus(1'b0, FUNCT_NONE, 32'h0, 32'h0);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    #1;
    vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL post_reset_busy: got %b want 0", busy); end
    vecCount++; if (hl_opcode !== 6'h0) begin missCount++; $display("[TB] FAIL post_reset_opcode: got %h want 00", hl_opcode); end
  endtask

  task automatic test_multu();
    int cyc;
    int vin;
    applyStimulus(1'b1, FUNCT_MULTU, 32'hFFFF_FFFF, 32'h2);
    #1;
    vecCount++; if (stall !== 1'b0) begin missCount++; $display("[TB] FAIL mul_accept_stall: got %b want 0", stall); end
    nextCycle();
    applyStimulus(1'b1, FUNCT_MFLO, 32'h0, 32'h0);
    #1;
    vecCount++; if (hl_opcode !== FUNCT_MULTU) begin missCount++; $display("[TB] FAIL mul_opcode: got %h want %h", hl_opcode, FUNCT_MULTU); end
    vecCount++; if (hl_b !== 32'h2) begin missCount++; $display("[TB] FAIL mul_hl_b: got %h want 2", hl_b); end
    vecCount++; if (busy !== 1'b1) begin missCount++; $display("[TB] FAIL mul_busy: got %b want 1", busy); end
    waitStall(cyc, vin);
    vecCount++; if (cyc != 3) begin missCount++; $display("[TB] FAIL mflo_stall_cycles: got %0d want 3", cyc); end
    vecCount++; if (rd_valid !== 1'b1) begin missCount++; $display("[TB] FAIL mflo_rd_valid: got %b want 1", rd_valid); end
    vecCount++; if (rd_data !== 32'hFFFF_FFFE) begin missCount++; $display("[TB] FAIL mflo_data: got %h want fffffffe", rd_data); end
    nextCycle();
    applyStimulus(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
    #1;
    vecCount++; if (rd_data !== 32'h1) begin missCount++; $display("[TB] FAIL mfhi_after_mul: got %h want 00000001", rd_data); end
    nextCycle();
    applyStimulus(1'b0, FUNCT_NONE, 32'h0, 32'h0);
  endtask

  task automatic test_divu();
    int cyc;
    int vin;
    applyStimulus(1'b1, FUNCT_DIVU, 32'd100, 32'd7);
    #1;
    vecCount++; if (stall !== 1'b0) begin missCount++; $display("[TB] FAIL divu_accept_stall: got %b want 0", stall); end
    nextCycle();
    applyStimulus(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
    #1;
    waitStall(cyc, vin);
    vecCount++; if (cyc != 8) begin missCount++; $display("[TB] FAIL divu_stall_cycles: got %0d want 8", cyc); end
    vecCount++; if (vin != 1) begin missCount++; $display("[TB] FAIL divu_valid_in_pulses: got %0d want 1", vin); end
    vecCount++; if (rd_data !== 32'd2) begin missCount++; $display("[TB] FAIL divu_mfhi: got %h want 00000002", rd_data); end
    nextCycle();
    applyStimulus(1'b1, FUNCT_MFLO, 32'h0, 32'h0);
    #1;
    vecCount++; if (rd_data !== 32'd14) begin missCount++; $display("[TB] FAIL divu_mflo: got %h want 0000000e", rd_data); end
    nextCycle();
    applyStimulus(1'b0, FUNCT_NONE, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int vin;
    applyStimulus(1'b1, FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    nextCycle();
    applyStimulus(1'b1, FUNCT_MFLO, 32'h0, 32'h0);
    #1;
    waitStall(cyc, vin);
    vecCount++; if (rd_data !== 32'hFFFF_FFFD) begin missCount++; $display("[TB] FAIL div_neg_lo: got %h want fffffffd", rd_data); end
    nextCycle();
    applyStimulus(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
    #1;
    vecCount++; if (rd_data !== 32'hFFFF_FFFF) begin missCount++; $display("[TB] FAIL div_neg_hi: got %h want ffffffff", rd_data); end
    nextCycle();
    applyStimulus(1'b1, FUNCT_DIV, 32'd20, 32'd3);
    nextCycle();
    applyStimulus(1'b1, FUNCT_DIV, 32'hFFFF_FF9C, 32'd7);
    #1;
    waitStall(cyc, vin);
    vecCount++; if (cyc != 8) begin missCount++; $display("[TB] FAIL b2b_div_stall: got %0d want 8", cyc); end
    nextCycle();
    applyStimulus(1'b1, FUNCT_MFLO, 32'h0, 32'h0);
    #1;
    vecCount++; if (hl_a !== 32'hFFFF_FF9C) begin missCount++; $display("[TB] FAIL b2b_div_operand: got %h want ffffff9c", hl_a); end
    waitStall(cyc, vin);
    vecCount++; if (rd_data !== 32'hFFFF_FFF2) begin missCount++; $display("[TB] FAIL b2b_div_lo: got %h want fffffff2", rd_data); end
    nextCycle();
    applyStimulus(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
    #1;
    vecCount++; if (rd_data !== 32'hFFFF_FFFE) begin missCount++; $display("[TB] FAIL b2b_div_hi: got %h want fffffffe", rd_data); end
    nextCycle();
    applyStimulus(1'b0, FUNCT_NONE, 32'h0, 32'h0);
  endtask

  task automatic test_div_zero();
    applyStimulus(1'b1, FUNCT_MTHI, 32'h1234, 32'h0);
    #1;
    vecCount++; if (hl_opcode !== FUNCT_MTHI) begin missCount++; $display("[TB] FAIL mthi_opcode: got %h want %h", hl_opcode, FUNCT_MTHI); end
    vecCount++; if (hl_a !== 32'h1234) begin missCount++; $display("[TB] FAIL mthi_a: got %h want 00001234", hl_a); end
    nextCycle();
    applyStimulus(1'b1, FUNCT_DIVU, 32'd5, 32'd0);
    #1;
    vecCount++; if (stall !== 1'b0) begin missCount++; $display("[TB] FAIL div0_stall: got %b want 0", stall); end
    vecCount++; if (hl_opcode !== 6'h0) begin missCount++; $display("[TB] FAIL div0_opcode: got %h want 00", hl_opcode); end
    nextCycle();
    applyStimulus(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
    #1;
    vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL div0_busy: got %b want 0", busy); end
    vecCount++; if (rd_data !== 32'h1234) begin missCount++; $display("[TB] FAIL div0_mfhi: got %h want 00001234", rd_data); end
    nextCycle();
    applyStimulus(1'b1, 6'b100000, 32'h55, 32'h66);
    #1;
    vecCount++; if (rd_valid !== 1'b0) begin missCount++; $display("[TB] FAIL unknown_rd_valid: got %b want 0", rd_valid); end
    nextCycle();
    applyStimulus(1'b0, FUNCT_NONE, 32'h0, 32'h0);
    #1;
    vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL unknown_busy: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    stubNoDone = 1'b1;
    applyStimulus(1'b1, FUNCT_DIVU, 32'd9, 32'd3);
    nextCycle();
    applyStimulus(1'b0, FUNCT_NONE, 32'h0, 32'h0);
    repeat (39) nextCycle();
    #1;
    vecCount++; if (busy !== 1'b1) begin missCount++; $display("[TB] FAIL timeout_busy_before: got %b want 1", busy); end
    vecCount++; if (err_timeout !== 1'b0) begin missCount++; $display("[TB] FAIL timeout_err_early: got %b want 0", err_timeout); end
    nextCycle();
    #1;
    vecCount++; if (err_timeout !== 1'b1) begin missCount++; $display("[TB] FAIL timeout_err: got %b want 1", err_timeout); end
    vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL timeout_busy_after: got %b want 0", busy); end
    vecCount++; if (hl_opcode !== 6'h0) begin missCount++; $display("[TB] FAIL timeout_opcode: got %h want 00", hl_opcode); end
    applyStimulus(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
    #1;
    vecCount++; if (stall !== 1'b0) begin missCount++; $display("[TB] FAIL timeout_idle_stall: got %b want 0", stall); end
    stubNoDone = 1'b0;
    nextCycle();
    applyStimulus(1'b0, FUNCT_NONE, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid_div();
    applyStimulus(1'b1, FUNCT_DIVU, 32'd50, 32'd5);
    nextCycle();
    applyStimulus(1'b0, FUNCT_NONE, 32'h0, 32'h0);
    nextCycle();
    #1;
    vecCount++; if (busy !== 1'b1) begin missCount++; $display("[TB] FAIL middiv_busy: got %b want 1", busy); end
    reset = 1'b0;
    applyStimulus(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
    #1;
    vecCount++; if (hl_opcode !== 6'h0) begin missCount++; $display("[TB] FAIL middiv_reset_opcode: got %h want 00", hl_opcode); end
    nextCycle();
    reset = 1'b1;
    #1;
    vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL middiv_after_busy: got %b want 0", busy); end
    vecCount++; if (stall !== 1'b0) begin missCount++; $display("[TB] FAIL middiv_after_stall: got %b want 0", stall); end
    vecCount++; if (err_timeout !== 1'b0) begin missCount++; $display("[TB] FAIL middiv_after_err: got %b want 0", err_timeout); end
    vecCount++; if (rd_valid !== 1'b1) begin missCount++; $display("[TB] FAIL middiv_after_rd_valid: got %b want 1", rd_valid); end
    nextCycle();
    applyStimulus(1'b0, FUNCT_NONE, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_multu();
    test_divu();
    test_back_to_back();
    test_div_zero();
    test_timeout();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
